// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Fetch stage of the RK16 core, directly upstream of the instruction decoder.
// Each instruction is 32 bits wide and is stored as two consecutive 16-bit
// halfwords in program memory. The high half is at pc and the low half is at
// pc+1. This block reads both halves, assembles them into {hi, lo}, and
// presents the result to the decoder through a valid/ready handshake.
// A redirect (jump/branch) from a later stage has priority in every state.
// It flushes any fetch that is in flight.
//
// Parameters
//   PC_W       width of the program counter and of the halfword address
//   RESET_PC   first fetch address after reset (bit 0 forced to 0)
//
// Ports
//   clk         in   core clock
//   rst_n       in   asynchronous active-low reset
//   mem_req     out  read request for mem_addr (memory always accepts)
//   mem_addr    out  halfword address of the current request
//   mem_rdata   in   read data, valid while mem_rvalid=1
//   mem_rvalid  in   read response, >=1 cycle after mem_req, one outstanding
//   inst        out  assembled instruction {hi, lo}
//   inst_pc     out  address of the high half of inst
//   inst_valid  out  inst / inst_pc hold a valid instruction
//   inst_ready  in   decoder accepts inst this cycle
//   jump_en     in   redirect request
//   jump_addr   in   redirect target (bit 0 ignored)
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic [15:0]     mem_rdata,
  input  logic            mem_rvalid,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            jump_en,
  input  logic [PC_W-1:0] jump_addr
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ_HI,
    S_WAIT_HI,
    S_REQ_LO,
    S_WAIT_LO,
    S_HOLD,
    S_DISCARD
  } state_t;

  // Instructions are halfword-pair aligned, so bit 0 of every fetch pc is 0.
  localparam logic [PC_W-1:0] ResetPcAligned = {RESET_PC[PC_W-1:1], 1'b0};

  state_t          r_state;
  state_t          w_stateNext;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pcNext;
  logic [15:0]     r_hi;
  logic [15:0]     w_hiNext;
  logic [31:0]     r_inst;
  logic [31:0]     w_instNext;
  logic [PC_W-1:0] r_instPc;
  logic [PC_W-1:0] w_instPcNext;

  logic [PC_W-1:0] w_jumpTarget;
  logic [PC_W-1:0] w_pcPlus1;
  logic [PC_W-1:0] w_pcPlus2;

  // Address arithmetic. The additions wrap modulo 2^PC_W, so a fetch that
  // starts at the top of memory continues at address 0.
  assign w_jumpTarget = {jump_addr[PC_W-1:1], 1'b0};
  assign w_pcPlus1    = r_pc + PC_W'(1);
  assign w_pcPlus2    = r_pc + PC_W'(2);

  // State and datapath registers. Reset clears the presented instruction,
  // so the decoder sees zeros, not stale data, after a mid-fetch reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_BOOT;
      r_pc     <= ResetPcAligned;
      r_hi     <= '0;
      r_inst   <= '0;
      r_instPc <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_pc     <= w_pcNext;
      r_hi     <= w_hiNext;
      r_inst   <= w_instNext;
      r_instPc <= w_instPcNext;
    end
  end

  // Next-state and datapath update.
  // A redirect always loads the aligned target into pc. The state it goes to
  // depends on whether a memory response is still owed. A response that
  // would arrive later must be absorbed in DISCARD. It must not be mistaken
  // for data at the new target.
  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = r_pc;
    w_hiNext     = r_hi;
    w_instNext   = r_inst;
    w_instPcNext = r_instPc;

    if (jump_en) begin
      w_pcNext = w_jumpTarget;
    end

    case (r_state)
      S_BOOT: begin
        w_stateNext = S_REQ_HI;
      end

      S_REQ_HI: begin
        // The request issued this cycle stays outstanding even on a redirect.
        w_stateNext = jump_en ? S_DISCARD : S_WAIT_HI;
      end

      S_WAIT_HI: begin
        if (jump_en) begin
          w_stateNext = mem_rvalid ? S_REQ_HI : S_DISCARD;
        end else if (mem_rvalid) begin
          w_hiNext    = mem_rdata;
          w_stateNext = S_REQ_LO;
        end
      end

      S_REQ_LO: begin
        w_stateNext = jump_en ? S_DISCARD : S_WAIT_LO;
      end

      S_WAIT_LO: begin
        if (jump_en) begin
          w_stateNext = mem_rvalid ? S_REQ_HI : S_DISCARD;
        end else if (mem_rvalid) begin
          w_instNext   = {r_hi, mem_rdata};
          w_instPcNext = r_pc;
          w_stateNext  = S_HOLD;
        end
      end

      S_HOLD: begin
        // A handshake in the same cycle as a redirect does not count, so pc
        // advances by two only when no redirect is present.
        if (jump_en) begin
          w_stateNext = S_REQ_HI;
        end else if (inst_ready) begin
          w_pcNext    = w_pcPlus2;
          w_stateNext = S_REQ_HI;
        end
      end

      S_DISCARD: begin
        if (mem_rvalid) begin
          w_stateNext = S_REQ_HI;
        end
      end

      default: begin
        w_stateNext = S_BOOT;
      end
    endcase
  end

  // Outputs are decoded from the state alone. mem_rvalid in any state other
  // than WAIT_HI, WAIT_LO or DISCARD has no effect.
  assign mem_req    = (r_state == S_REQ_HI) || (r_state == S_REQ_LO);
  assign mem_addr   = (r_state == S_REQ_LO) ? w_pcPlus1 : r_pc;
  assign inst_valid = (r_state == S_HOLD);
  assign inst       = r_inst;
  assign inst_pc    = r_instPc;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Directed testbench for inst_fetch. It uses two instances:
//   dut   RESET_PC = 0, memory model with selectable latency
//   dutW  RESET_PC = 0xFFFE, memory model with 1-cycle latency
// Both share clk and rst_n. Inputs and checks happen on the falling edge.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;

  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        jump_en;
  logic [15:0] jump_addr;

  logic        wMemReq;
  logic [15:0] wMemAddr;
  logic [15:0] wMemRdata;
  logic        wMemRvalid;
  logic [31:0] wInst;
  logic [15:0] wInstPc;
  logic        wInstValid;
  logic        wInstReady;
  logic        wJumpEn;
  logic [15:0] wJumpAddr;

  int testsRun    = 0;
  int testsFailed = 0;

  int          latA = 1;
  int          cntA = 0;
  logic [15:0] addrA;
  int          cntW = 0;
  logic [15:0] addrW;

  inst_fetch #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr)
  );

  inst_fetch #(.PC_W(16), .RESET_PC(16'hFFFE)) dutW (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (wMemReq),
    .mem_addr   (wMemAddr),
    .mem_rdata  (wMemRdata),
    .mem_rvalid (wMemRvalid),
    .inst       (wInst),
    .inst_pc    (wInstPc),
    .inst_valid (wInstValid),
    .inst_ready (wInstReady),
    .jump_en    (wJumpEn),
    .jump_addr  (wJumpAddr)
  );

  // Program memory contents. Words 0 and 1 hold fixed values. Every other
  // address holds a word derived from its own address.
  function automatic logic [15:0] memWord(input logic [15:0] addr);
    if (addr == 16'h0000)      return 16'h1234;
    else if (addr == 16'h0001) return 16'h5678;
    else                       return addr ^ 16'hA5C3;
  endfunction

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model for dut. A request seen in cycle c produces a one-cycle
  // response in cycle c+latA. A response that is still pending survives a
  // reset of the DUT, which lets the bench deliver a stray late reply.
  always @(negedge clk) begin
    mem_rvalid = 1'b0;
    if (cntA > 0) begin
      cntA = cntA - 1;
      if (cntA == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = memWord(addrA);
      end
    end
    if (mem_req) begin
      cntA  = latA;
      addrA = mem_addr;
    end
  end

  // Memory model for dutW, with a fixed latency of one cycle.
  always @(negedge clk) begin
    wMemRvalid = 1'b0;
    if (cntW > 0) begin
      cntW = cntW - 1;
      if (cntW == 0) begin
        wMemRvalid = 1'b1;
        wMemRdata  = memWord(addrW);
      end
    end
    if (wMemReq) begin
      cntW  = 1;
      addrW = wMemAddr;
    end
  end

  // Guards against the bench hanging if nothing else ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic jump,
                               input logic [15:0] target);
    inst_ready = ready;
    jump_en    = jump;
    jump_addr  = target;
  endtask

  task automatic waitForReq(input int maxCycles);
    int n = 0;
    while (!mem_req && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqWithinBound", {31'd0, mem_req}, 32'd1);
  endtask

  task automatic waitForValid(input int maxCycles);
    int n = 0;
    while (!inst_valid && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("validWithinBound", {31'd0, inst_valid}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b1;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    wMemRdata  = '0;
    wMemRvalid = 1'b0;
    wInstReady = 1'b1;
    wJumpEn    = 1'b0;
    wJumpAddr  = '0;
    applyStimulus(1'b1, 1'b0, 16'h0000);
    #2 rst_n = 1'b0;

    // Reset values of both instances.
    repeat (2) @(negedge clk);
    checkOutput("rstValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rstInst", inst, 32'h0);
    checkOutput("rstInstPc", {16'd0, inst_pc}, 32'h0);
    checkOutput("rstMemReq", {31'd0, mem_req}, 32'd0);
    checkOutput("rstWValid", {31'd0, wInstValid}, 32'd0);

    // First fetch, 1-cycle latency, with the decoder always ready.
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("c1MemReq", {31'd0, mem_req}, 32'd1);
    checkOutput("c1MemAddr", {16'd0, mem_addr}, 32'h0000);
    checkOutput("c1WMemAddr", {16'd0, wMemAddr}, 32'hFFFE);
    @(negedge clk);
    checkOutput("c2MemReq", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    checkOutput("c3MemAddr", {16'd0, mem_addr}, 32'h0001);
    checkOutput("c3WMemReq", {31'd0, wMemReq}, 32'd1);
    checkOutput("c3WMemAddr", {16'd0, wMemAddr}, 32'hFFFF);
    @(negedge clk);
    checkOutput("c4Valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    checkOutput("c5Valid", {31'd0, inst_valid}, 32'd1);
    checkOutput("c5Inst", inst, 32'h1234_5678);
    checkOutput("c5InstPc", {16'd0, inst_pc}, 32'h0000);
    checkOutput("c5WValid", {31'd0, wInstValid}, 32'd1);
    checkOutput("c5WInst", wInst, {memWord(16'hFFFE), memWord(16'hFFFF)});
    checkOutput("c5WInstPc", {16'd0, wInstPc}, 32'hFFFE);
    @(negedge clk);
    checkOutput("c6MemAddr", {16'd0, mem_addr}, 32'h0002);
    checkOutput("c6MemReq", {31'd0, mem_req}, 32'd1);
    checkOutput("c6Valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("c6WMemReq", {31'd0, wMemReq}, 32'd1);
    checkOutput("c6WMemAddr", {16'd0, wMemAddr}, 32'h0000);

    // Decoder stall: hold the instruction at pc=2 while inst_ready=0.
    applyStimulus(1'b0, 1'b0, 16'h0000);
    repeat (4) @(negedge clk);
    checkOutput("stallValid", {31'd0, inst_valid}, 32'd1);
    checkOutput("stallInst", inst, {memWord(16'h0002), memWord(16'h0003)});
    checkOutput("stallInstPc", {16'd0, inst_pc}, 32'h0002);
    latA = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("holdValid", {31'd0, inst_valid}, 32'd1);
      checkOutput("holdInst", inst, {memWord(16'h0002), memWord(16'h0003)});
      checkOutput("holdInstPc", {16'd0, inst_pc}, 32'h0002);
      checkOutput("holdMemReq", {31'd0, mem_req}, 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    checkOutput("advMemAddr", {16'd0, mem_addr}, 32'h0004);
    checkOutput("advMemReq", {31'd0, mem_req}, 32'd1);
    checkOutput("advValid", {31'd0, inst_valid}, 32'd0);

    // Redirect while in WAIT_HI with 3-cycle latency; the old reply is dropped.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 16'h0041);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("discMemReq", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    checkOutput("disc2MemReq", {31'd0, mem_req}, 32'd0);
    checkOutput("disc2Valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    checkOutput("jmpHiReq", {31'd0, mem_req}, 32'd1);
    checkOutput("jmpHiAddr", {16'd0, mem_addr}, 32'h0040);
    @(negedge clk);
    waitForReq(10);
    checkOutput("jmpLoAddr", {16'd0, mem_addr}, 32'h0041);
    waitForValid(10);
    checkOutput("jmpInst", inst, {memWord(16'h0040), memWord(16'h0041)});
    checkOutput("jmpInstPc", {16'd0, inst_pc}, 32'h0040);

    // Redirect in HOLD together with inst_ready: the transfer does not count.
    applyStimulus(1'b1, 1'b1, 16'h0100);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkOutput("holdJmpValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("holdJmpReq", {31'd0, mem_req}, 32'd1);
    checkOutput("holdJmpAddr", {16'd0, mem_addr}, 32'h0100);

    // Reset pulsed during WAIT_LO, followed by a stray late response in BOOT.
    @(negedge clk);
    waitForReq(10);
    checkOutput("preRstLoAddr", {16'd0, mem_addr}, 32'h0101);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", {31'd0, inst_valid}, 32'd0);
    checkOutput("midRstInst", inst, 32'h0);
    checkOutput("midRstInstPc", {16'd0, inst_pc}, 32'h0);
    checkOutput("midRstMemReq", {31'd0, mem_req}, 32'd0);
    checkOutput("midRstMemAddr", {16'd0, mem_addr}, 32'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    latA  = 1;
    @(negedge clk);
    checkOutput("restartReq", {31'd0, mem_req}, 32'd1);
    checkOutput("restartAddr", {16'd0, mem_addr}, 32'h0000);
    checkOutput("restartValid", {31'd0, inst_valid}, 32'd0);
    waitForValid(10);
    checkOutput("restartInst", inst, 32'h1234_5678);
    checkOutput("restartInstPc", {16'd0, inst_pc}, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
